// File: rtl/game_flow_controller_if.sv
// Control/status bundle between the game sequencer and main/display logic.
// The controller takes the master view; the consumer side (main, display, bench) takes the slave view.
interface game_flow_controller_if;
  logic       start;
  logic       colision;
  logic       upsig;
  logic       upsig_fast;
  logic       drop;
  logic       alive;
  logic [1:0] lives;
  logic [1:0] state;
  logic       game_over;

  modport master (
    input  start,
    input  colision,
    output upsig,
    output upsig_fast,
    output drop,
    output alive,
    output lives,
    output state,
    output game_over
  );

  modport slave (
    output start,
    output colision,
    input  upsig,
    input  upsig_fast,
    input  drop,
    input  alive,
    input  lives,
    input  state,
    input  game_over
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game sequencer: generates main's update/scroll/drop timing and tracks lives
// through the IDLE/RUN/CRASH/OVER game states.
module game_flow_controller #(
  parameter int unsigned UPD_DIV     = 1000000,
  parameter int unsigned FAST_DIV    = 250000,
  parameter int unsigned CRASH_TICKS = 48,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned DROP_MIN    = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  game_flow_controller_if.master gfc
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned CRASH_W = 8;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned LFSR_W  = 8;
  localparam int unsigned LIVES_W = 2;

  localparam logic [CNT_W-1:0]   UPD_LAST   = CNT_W'(UPD_DIV - 1);
  localparam logic [CNT_W-1:0]   FAST_LAST  = CNT_W'(FAST_DIV - 1);
  localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_TICKS - 1);
  localparam logic [DROP_W-1:0]  DROP_BASE  = DROP_W'(DROP_MIN);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LFSR_W-1:0]  LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CRASH = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [LIVES_W-1:0]   lives_q;
  logic [LIVES_W-1:0]   lives_d;
  logic [CRASH_W-1:0]   crash_cnt_q;
  logic [CRASH_W-1:0]   crash_cnt_d;
  logic                 presc_clr;
  logic                 run_entry;

  logic                 start_s1;
  logic                 start_s2;
  logic                 start_s3;
  logic                 start_rise;
  logic                 col_q;
  logic                 col_rise;

  logic [CNT_W-1:0]     cnt_upd;
  logic [CNT_W-1:0]     cnt_fast;
  logic [CNT_W-1:0]     cnt_upd_nxt;
  logic [CNT_W-1:0]     cnt_fast_nxt;
  logic                 tick_upd;
  logic                 tick_fast;

  logic [LFSR_W-1:0]    lfsr;
  logic [DROP_W-1:0]    drop_cnt;
  logic [DROP_W-1:0]    drop_target;
  logic                 drop_q;
  logic                 in_run;
  logic                 upd_run;

  // Two-flop synchroniser for the raw button plus a third flop for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      col_q    <= 1'b0;
    end else begin
      start_s1 <= gfc.start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      col_q    <= gfc.colision;
    end
  end

  assign start_rise = start_s2 & ~start_s3;
  assign col_rise   = gfc.colision & ~col_q;

  // Prescalers free-run everywhere; only a fresh game (from IDLE/OVER) realigns them
  always_comb begin
    if (presc_clr) begin
      cnt_upd_nxt  = '0;
      cnt_fast_nxt = '0;
    end else begin
      cnt_upd_nxt  = (cnt_upd == UPD_LAST)   ? '0 : cnt_upd + CNT_W'(1);
      cnt_fast_nxt = (cnt_fast == FAST_LAST) ? '0 : cnt_fast + CNT_W'(1);
    end
  end

  // Ticks are registered so they line up with the cycle holding the last count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_upd   <= '0;
      cnt_fast  <= '0;
      tick_upd  <= 1'b0;
      tick_fast <= 1'b0;
    end else begin
      cnt_upd   <= cnt_upd_nxt;
      cnt_fast  <= cnt_fast_nxt;
      tick_upd  <= (cnt_upd_nxt == UPD_LAST);
      tick_fast <= (cnt_fast_nxt == FAST_LAST);
    end
  end

  // 8-bit Fibonacci LFSR, taps 8,6,5,4; a non-zero seed keeps it off the all-zero lockup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign in_run  = (state_q == ST_RUN);
  assign upd_run = tick_upd & in_run;

  // Drop scheduler: a drop fires every drop_target+1 update ticks, target re-rolled per drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt    <= '0;
      drop_target <= DROP_BASE;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= upd_run & (drop_cnt == drop_target);
      if (run_entry) begin
        drop_cnt    <= '0;
        drop_target <= DROP_BASE;
      end else if (upd_run) begin
        if (drop_cnt == drop_target) begin
          drop_cnt    <= '0;
          drop_target <= DROP_BASE + DROP_W'(lfsr[3:0]);
        end else begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end
    end
  end

  // Game state, lives and crash timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      crash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      crash_cnt_q <= crash_cnt_d;
    end
  end

  // Next-state logic; collision is checked before start so it wins in RUN
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    crash_cnt_d = crash_cnt_q;
    presc_clr   = 1'b0;
    run_entry   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d   = ST_RUN;
          lives_d   = LIVES_INIT;
          presc_clr = 1'b1;
          run_entry = 1'b1;
        end
      end
      ST_RUN: begin
        if (col_rise) begin
          if (lives_q > LIVES_W'(1)) begin
            state_d     = ST_CRASH;
            lives_d     = lives_q - LIVES_W'(1);
            crash_cnt_d = '0;
          end else begin
            state_d = ST_OVER;
            lives_d = '0;
          end
        end
      end
      ST_CRASH: begin
        if (tick_upd) begin
          if (crash_cnt_q == CRASH_LAST) begin
            state_d   = ST_RUN;
            run_entry = 1'b1;
          end else begin
            crash_cnt_d = crash_cnt_q + CRASH_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are ANDs of registers only, so they stay glitch-free
  assign gfc.upsig      = upd_run;
  assign gfc.upsig_fast = tick_fast & in_run;
  assign gfc.drop       = drop_q & in_run;
  assign gfc.alive      = in_run;
  assign gfc.game_over  = (state_q == ST_OVER);
  assign gfc.lives      = lives_q;
  assign gfc.state      = state_q;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer that sits directly upstream of main.
- Consumes main's colision output and the start button.
- Produces main's timing and control inputs: upsig, upsig_fast, drop, alive.
- Also tracks lives and IDLE/RUN/CRASH/OVER state for the display and LEDs.

Parameters:
UPD_DIV, 1000000, clk cycles per object-update tick (2..2^24)
FAST_DIV, 250000, clk cycles per background-scroll tick (2..2^24)
CRASH_TICKS, 48, update ticks spent frozen in CRASH (1..255)
LIVES, 3, lives loaded at reset/start (1..3)
DROP_MIN, 12, minimum update ticks between obstacle drops (1..239)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  raw start button, asynchronous to clk
colision  in  1  player/obstacle overlap, clk domain
upsig  out  1  one-cycle object-update pulse
upsig_fast  out  1  one-cycle background-scroll pulse
drop  out  1  one-cycle spawn-obstacle request
alive  out  1  high only in RUN
lives  out  2  remaining lives
state  out  2  00 IDLE, 01 RUN, 10 CRASH, 11 OVER
game_over  out  1  high only in OVER

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; lives=LIVES; all counters=0; LFSR=8'hA5; sync flops=0.
  - upsig, upsig_fast, drop, alive, game_over all =0.
- start sync and edge detect:
  - start passes through two flops, then a third flop for edge detect.
  - start_rise = s2 & ~s3.
  - The state changes on the edge after start_rise, i.e. 3 clk edges after start is first sampled high.
- colision: registered to col_q; col_rise = colision & ~col_q.
  - A collision held high costs exactly one life.
- Prescalers:
  - cnt_upd counts 0..UPD_DIV-1 and wraps; cnt_fast counts 0..FAST_DIV-1 and wraps. Both 24 bits.
  - Both clear on every transition into RUN from IDLE or OVER, and keep counting through CRASH.
  - tick_upd / tick_fast are registered and high one cycle each wrap.
- Output decode (AND of registers, glitch-free):
  - upsig = tick_upd & RUN; upsig_fast = tick_fast & RUN.
  - alive = RUN; game_over = OVER.
  - First upsig occurs in the UPD_DIV-th cycle of RUN, counting alive's first cycle as 1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every clk, never zero.
- Drop scheduling (RUN only):
  - drop_cnt increments on each upsig.
  - When drop_cnt==drop_target at an upsig, a drop pulse is registered for the next cycle (1 cycle after upsig).
  - On that same upsig, drop_cnt clears and drop_target = DROP_MIN + LFSR[3:0].
  - drop_target=DROP_MIN on RUN entry, including from CRASH; drop_cnt clears on RUN entry.
  - drop is gated by RUN, so a pending drop is lost if state leaves RUN that edge.
- FSM:
  - IDLE: start_rise -> RUN, lives=LIVES.
  - RUN:
    - col_rise and lives>1 -> CRASH, lives-1.
    - col_rise and lives==1 -> OVER, lives=0.
    - start_rise ignored.
  - CRASH:
    - crash_cnt (8 bits) clears on entry and increments on each tick_upd.
    - Reaching CRASH_TICKS -> RUN; prescalers are not cleared.
    - colision ignored; col_q still tracks.
  - OVER: start_rise -> RUN, lives=LIVES, prescalers cleared.
- Simultaneous events:
  - col_rise and start_rise in RUN: collision wins.
  - col_rise on the same edge as a tick: state changes, and the tick is not output (RUN gating).
- Reset mid-game: immediately IDLE with all outputs at reset values, regardless of state.

Test Plan:
Common bench parameters: UPD_DIV=4, FAST_DIV=2, CRASH_TICKS=3, LIVES=2, DROP_MIN=2.
1. Reset release, no start, 50 cycles -> state=00, alive=0, upsig=upsig_fast=drop=0, lives=2.
2. start high at edge 0 -> state=01 after edge 2. Then upsig every 4 cycles, first in RUN cycle 4; upsig_fast every 2 cycles. First drop is 1 cycle after the 3rd upsig (drop_cnt 0->2), i.e. after the upsig on which drop_cnt==2.
3. In RUN, colision held high 40 cycles -> one col_rise only: lives=1, state=10 for 3 update ticks, then 01 with alive=1 while colision still high, lives still 1.
4. Drop colision low then pulse high again -> lives=0, state=11, game_over=1, alive=0, no further upsig/drop. Then start pulse -> state=01, lives=2, cnt_upd cleared (first upsig 4 cycles later).
5. Assert colision and start in the same cycle in RUN -> CRASH entered, lives decremented, start ignored.
6. Assert reset=0 mid-CRASH, asynchronously between edges -> outputs zero immediately; after release, state=00 and lives=2.
